// File: rtl/alu_pkg.sv
// Shared definitions for the integer ALU: operand width, shift-amount width
// and the 4-bit operation encoding.
package alu_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_OR  = 4'd2,
        OP_XOR = 4'd3,
        OP_AND = 4'd4,
        OP_LTU = 4'd5,
        OP_LTS = 4'd6,
        OP_SRU = 4'd7,
        OP_SLU = 4'd8,
        OP_SRS = 4'd9,
        OP_SLS = 4'd10
    } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational log-depth barrel shifter shared by all shift operations.
// Left shifts reuse the right-shift network by bit-reversing input and output.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] src,
    input  logic [SW-1:0]    shamt,
    input  logic             dir_left,
    input  logic             arith,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] src_rev;
    logic [WIDTH-1:0] stage [0:SW];
    logic [WIDTH-1:0] stage_rev;
    logic             fill;

    // Sign fill only applies to arithmetic right shifts.
    assign fill = arith & ~dir_left & src[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign src_rev[gi]   = src[WIDTH-1-gi];
            assign stage_rev[gi] = stage[SW][WIDTH-1-gi];
        end
    endgenerate

    assign stage[0] = dir_left ? src_rev : src;

    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_stage
            localparam int STEP = 1 << gi;
            assign stage[gi+1] = shamt[gi]
                ? {{STEP{fill}}, stage[gi][WIDTH-1:STEP]}
                : stage[gi];
        end
    endgenerate

    assign result = dir_left ? stage_rev : stage[SW];

endmodule

// File: rtl/alu_core.sv
// 32-bit RISC-V integer ALU with a registered result and valid strobe.
// One-cycle latency, one operation per cycle, no backpressure.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] O,
    output logic             out_valid
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ltu;
    logic             lts;
    logic [WIDTH-1:0] shift_result;
    logic             shift_left;
    logic             shift_arith;
    logic [WIDTH-1:0] result_next;

    assign sum  = X + Y;
    assign diff = X - Y;
    assign ltu  = X < Y;
    assign lts  = $signed(X) < $signed(Y);

    assign shift_left  = (operation == OP_SLU) || (operation == OP_SLS);
    assign shift_arith = (operation == OP_SRS);

    alu_shifter #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_shifter (
        .src      (X),
        .shamt    (Y[SW-1:0]),
        .dir_left (shift_left),
        .arith    (shift_arith),
        .result   (shift_result)
    );

    always_comb begin
        result_next = '0;
        case (alu_op_e'(operation))
            OP_ADD:                         result_next = sum;
            OP_SUB:                         result_next = diff;
            OP_OR:                          result_next = X | Y;
            OP_XOR:                         result_next = X ^ Y;
            OP_AND:                         result_next = X & Y;
            OP_LTU:                         result_next = {{(WIDTH-1){1'b0}}, ltu};
            OP_LTS:                         result_next = {{(WIDTH-1){1'b0}}, lts};
            OP_SRU, OP_SLU, OP_SRS, OP_SLS: result_next = shift_result;
            default:                        result_next = '0;
        endcase
    end

    // O holds its last value while no operation is being captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            O         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                O <= result_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Directed and randomized self-checking bench for alu_core.
`timescale 1ns/1ps
module tb_alu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  operation;
    logic [31:0] X;
    logic [31:0] Y;
    logic [31:0] O;
    logic        out_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_core dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .operation (operation),
        .X         (X),
        .Y         (Y),
        .O         (O),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        in_valid  = v;
        operation = op;
        X         = x;
        Y         = y;
        @(posedge clk);
        #1;
        $display("txn v=%0b op=%0d X=%08h Y=%08h -> O=%08h out_valid=%0b", v, op, x, y, O, out_valid);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; operation = 4'd0; X = '0; Y = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (O !== 32'h0 || out_valid !== 1'b0)
            $display("FAIL reset_init O=%08h ov=%0b expected O=00000000 ov=0", O, out_valid);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 4'd0, 32'd1, 32'd2);
        total_cnt++;
        if (O !== 32'd3 || out_valid !== 1'b1)
            $display("FAIL pre_reset_add O=%08h ov=%0b expected O=00000003 ov=1", O, out_valid);
        else pass_cnt++;
        // Assert reset asynchronously between edges while a capture is pending.
        @(negedge clk);
        X = 32'd100; Y = 32'd1;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (O !== 32'h0 || out_valid !== 1'b0)
            $display("FAIL async_reset O=%08h ov=%0b expected O=00000000 ov=0", O, out_valid);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (O !== 32'h0 || out_valid !== 1'b0)
            $display("FAIL reset_held O=%08h ov=%0b expected O=00000000 ov=0", O, out_valid);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 4'd0, 32'd5, 32'd7);
        total_cnt++;
        if (O !== 32'd12 || out_valid !== 1'b1)
            $display("FAIL post_reset_add O=%08h ov=%0b expected O=0000000c ov=1", O, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_arith();
        logic [31:0] x, y, exp;
        step(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1);
        total_cnt++;
        if (O !== 32'h0) $display("FAIL add_wrap O=%08h expected 00000000", O);
        else pass_cnt++;
        step(1'b1, 4'd1, 32'd0, 32'd1);
        total_cnt++;
        if (O !== 32'hFFFF_FFFF) $display("FAIL sub_wrap O=%08h expected ffffffff", O);
        else pass_cnt++;
        for (int op = 0; op < 5; op++) begin
            for (int i = 0; i < 32; i++) begin
                x = $urandom; y = $urandom;
                case (op)
                    0:       exp = x + y;
                    1:       exp = x - y;
                    2:       exp = x | y;
                    3:       exp = x ^ y;
                    default: exp = x & y;
                endcase
                step(1'b1, op[3:0], x, y);
                total_cnt++;
                if (O !== exp || out_valid !== 1'b1)
                    $display("FAIL arith_op%0d O=%08h ov=%0b expected %08h ov=1", op, O, out_valid, exp);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_compare();
        logic [31:0] x, y, exp_u, exp_s;
        step(1'b1, 4'd5, 32'h8000_0000, 32'h7FFF_FFFF);
        total_cnt++;
        if (O !== 32'd0) $display("FAIL ltu_minpos O=%08h expected 00000000", O);
        else pass_cnt++;
        step(1'b1, 4'd6, 32'h8000_0000, 32'h7FFF_FFFF);
        total_cnt++;
        if (O !== 32'd1) $display("FAIL lts_minpos O=%08h expected 00000001", O);
        else pass_cnt++;
        step(1'b1, 4'd5, 32'h1234, 32'h1234);
        total_cnt++;
        if (O !== 32'd0) $display("FAIL ltu_equal O=%08h expected 00000000", O);
        else pass_cnt++;
        step(1'b1, 4'd6, 32'h1234, 32'h1234);
        total_cnt++;
        if (O !== 32'd0) $display("FAIL lts_equal O=%08h expected 00000000", O);
        else pass_cnt++;
        for (int i = 0; i < 32; i++) begin
            x = $urandom; y = $urandom;
            if (i % 4 == 0) y = x ^ 32'h8000_0000;
            exp_u = (x < y) ? 32'd1 : 32'd0;
            exp_s = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            step(1'b1, 4'd5, x, y);
            total_cnt++;
            if (O !== exp_u) $display("FAIL ltu_rand O=%08h expected %08h", O, exp_u);
            else pass_cnt++;
            step(1'b1, 4'd6, x, y);
            total_cnt++;
            if (O !== exp_s) $display("FAIL lts_rand O=%08h expected %08h", O, exp_s);
            else pass_cnt++;
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
    } vec_t;

    task automatic test_shift();
        vec_t vecs [10];
        logic [31:0] x, y, exp;
        vecs[0] = '{4'd7,  32'h8000_0000, 32'd31,        32'h0000_0001};
        vecs[1] = '{4'd9,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF};
        vecs[2] = '{4'd8,  32'h0000_0001, 32'd31,        32'h8000_0000};
        vecs[3] = '{4'd7,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000};
        vecs[4] = '{4'd8,  32'h0000_0003, 32'h0000_0021, 32'h0000_0006};
        vecs[5] = '{4'd8,  32'h1234_5678, 32'd0,         32'h1234_5678};
        vecs[6] = '{4'd9,  32'h9234_5678, 32'h0000_0020, 32'h9234_5678};
        vecs[7] = '{4'd9,  32'h8000_0000, 32'd4,         32'hF800_0000};
        vecs[8] = '{4'd9,  32'h7000_0000, 32'd4,         32'h0700_0000};
        vecs[9] = '{4'd10, 32'h0000_00F0, 32'd8,         32'h0000_F000};
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].op, vecs[i].x, vecs[i].y);
            total_cnt++;
            if (O !== vecs[i].exp)
                $display("FAIL shift_vec%0d O=%08h expected %08h", i, O, vecs[i].exp);
            else pass_cnt++;
        end
        for (int i = 0; i < 16; i++) begin
            x = $urandom; y = $urandom;
            exp = x << y[4:0];
            step(1'b1, 4'd10, x, y);
            total_cnt++;
            if (O !== exp) $display("FAIL sls_rand O=%08h expected %08h", O, exp);
            else pass_cnt++;
            step(1'b1, 4'd8, x, y);
            total_cnt++;
            if (O !== exp) $display("FAIL slu_rand O=%08h expected %08h", O, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        step(1'b1, 4'd0, 32'h11, 32'h22);
        total_cnt++;
        if (O !== 32'h33 || out_valid !== 1'b1)
            $display("FAIL hold_setup O=%08h ov=%0b expected O=00000033 ov=1", O, out_valid);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd3, 32'hDEAD_BEEF, 32'h1234_5678);
            total_cnt++;
            if (O !== 32'h33 || out_valid !== 1'b0)
                $display("FAIL hold_idle%0d O=%08h ov=%0b expected O=00000033 ov=0", i, O, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        vec_t vecs [5];
        vecs[0] = '{4'd0, 32'd10,          32'd20,          32'd30};
        vecs[1] = '{4'd1, 32'd10,          32'd20,          32'hFFFF_FFF6};
        vecs[2] = '{4'd3, 32'hFF00_FF00,   32'h0F0F_0F0F,   32'hF00F_F00F};
        vecs[3] = '{4'd4, 32'hFF00_FF00,   32'h0F0F_0F0F,   32'h0F00_0F00};
        vecs[4] = '{4'd2, 32'hFF00_0000,   32'h0000_00FF,   32'hFF00_00FF};
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].op, vecs[i].x, vecs[i].y);
            total_cnt++;
            if (O !== vecs[i].exp || out_valid !== 1'b1)
                $display("FAIL b2b_%0d O=%08h ov=%0b expected %08h ov=1", i, O, out_valid, vecs[i].exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reserved();
        for (int op = 11; op < 16; op++) begin
            step(1'b1, 4'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
            step(1'b1, op[3:0], 32'hF0F0_F0F0, 32'h0F0F_0F0F);
            total_cnt++;
            if (O !== 32'h0 || out_valid !== 1'b1)
                $display("FAIL reserved_op%0d O=%08h ov=%0b expected O=00000000 ov=1", op, O, out_valid);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_compare();
        test_shift();
        test_hold();
        test_back_to_back();
        test_reserved();
        step(1'b0, 4'd0, 32'd0, 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule
